// File: rtl/rc4_keystream_gen.sv
// rc4_keystream_gen: RC4 keystream engine. Loads a variable-length key over a
// valid/ready stream, fills and key-schedules the S-box, optionally discards
// the first DROP outputs, then emits one registered keystream symbol per
// PRGA step on a back-pressured valid/ready output.
module rc4_keystream_gen #(
  parameter int W       = 8,
  parameter int KEY_MAX = 16,
  parameter int DROP    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key_data,
  input  logic         key_valid,
  input  logic         key_last,
  output logic         key_ready,
  input  logic         rekey,
  output logic [W-1:0] ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         busy
);

  localparam int KIW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int LW  = $clog2(KEY_MAX + 1);
  localparam int DW  = (DROP > 0) ? $clog2(DROP + 1) : 1;

  typedef enum logic [3:0] {
    ST_LOAD,
    ST_INIT,
    ST_KSA1,
    ST_KSA2,
    ST_DRP1,
    ST_DRP2,
    ST_GEN1,
    ST_GEN2,
    ST_HOLD
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_i;
  logic [W-1:0]   r_j;
  logic [W-1:0]   r_si;        // S[i] captured in the first half of a step
  logic [LW-1:0]  r_len;       // number of key symbols loaded (L)
  logic [KIW-1:0] r_kidx;      // i mod L, kept as a wrapping counter
  logic [DW-1:0]  r_drop_cnt;
  logic [W-1:0]   r_ks_data;
  logic           r_ks_valid;

  // S-box and key store; reads are asynchronous because a step needs
  // several lookups of entries written on the previous cycle
  logic [W-1:0]   r_sbox [2**W];
  logic [W-1:0]   r_key  [KEY_MAX];

  logic [W-1:0]   w_i_inc;
  logic [W-1:0]   w_s_i;
  logic [W-1:0]   w_s_inc;
  logic [W-1:0]   w_s_j;
  logic [W-1:0]   w_k;
  logic [W-1:0]   w_t;
  logic [W-1:0]   w_sym;
  logic           w_swap;
  logic           w_key_xfer;
  logic           w_key_end;
  logic           w_kidx_wrap;
  logic           w_i_max;

  assign w_i_inc     = r_i + W'(1);
  assign w_s_i       = r_sbox[r_i];
  assign w_s_inc     = r_sbox[w_i_inc];
  assign w_s_j       = r_sbox[r_j];
  assign w_k         = r_key[r_kidx];
  assign w_t         = r_si + w_s_j;
  assign w_i_max     = (r_i == {W{1'b1}});
  assign w_kidx_wrap = ((LW'(r_kidx) + LW'(1)) == r_len);

  // Output symbol is S[t] after the swap; the swap is only being written this
  // cycle, so the two swapped slots are forwarded from their old values
  assign w_sym = (w_t == r_i) ? w_s_j :
                 (w_t == r_j) ? r_si  : r_sbox[w_t];

  assign w_swap = (r_state == ST_KSA2) || (r_state == ST_DRP2) ||
                  (r_state == ST_GEN2);

  assign key_ready  = (r_state == ST_LOAD);
  assign w_key_xfer = key_valid && key_ready;
  assign w_key_end  = key_last || (r_len == LW'(KEY_MAX - 1));

  assign busy = (r_state == ST_INIT) || (r_state == ST_KSA1) ||
                (r_state == ST_KSA2) || (r_state == ST_DRP1) ||
                (r_state == ST_DRP2);

  assign ks_data  = r_ks_data;
  assign ks_valid = r_ks_valid;

  // S-box write port: identity fill during INIT, two-entry swap otherwise
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_sbox[r_i] <= r_i;
    end else if (w_swap) begin
      // when i == j both writes carry the same value
      r_sbox[r_i] <= w_s_j;
      r_sbox[r_j] <= r_si;
    end
  end

  // Key store write port: one symbol per accepted transfer
  always_ff @(posedge clk) begin
    if (w_key_xfer) begin
      r_key[r_len[KIW-1:0]] <= key_data;
    end
  end

  // Control FSM with registered keystream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_LOAD;
      r_i        <= '0;
      r_j        <= '0;
      r_si       <= '0;
      r_len      <= '0;
      r_kidx     <= '0;
      r_drop_cnt <= '0;
      r_ks_data  <= '0;
      r_ks_valid <= 1'b0;
    end else if (rekey && (r_state != ST_LOAD)) begin
      r_state    <= ST_LOAD;
      r_ks_valid <= 1'b0;
      r_len      <= '0;
      r_i        <= '0;
      r_j        <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_key_xfer) begin
            r_len <= r_len + LW'(1);
            if (w_key_end) begin
              r_i     <= '0;
              r_state <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          if (w_i_max) begin
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= ST_KSA1;
          end else begin
            r_i <= w_i_inc;
          end
        end
        ST_KSA1: begin
          r_j     <= r_j + w_s_i + w_k;
          r_si    <= w_s_i;
          r_state <= ST_KSA2;
        end
        ST_KSA2: begin
          r_kidx <= w_kidx_wrap ? '0 : r_kidx + KIW'(1);
          if (w_i_max) begin
            r_i        <= '0;
            r_j        <= '0;
            r_drop_cnt <= '0;
            r_state    <= (DROP > 0) ? ST_DRP1 : ST_GEN1;
          end else begin
            r_i     <= w_i_inc;
            r_state <= ST_KSA1;
          end
        end
        ST_DRP1, ST_GEN1: begin
          r_i     <= w_i_inc;
          r_j     <= r_j + w_s_inc;
          r_si    <= w_s_inc;
          r_state <= (r_state == ST_DRP1) ? ST_DRP2 : ST_GEN2;
        end
        ST_DRP2: begin
          r_drop_cnt <= r_drop_cnt + DW'(1);
          r_state    <= (r_drop_cnt == DW'(DROP - 1)) ? ST_GEN1 : ST_DRP1;
        end
        ST_GEN2: begin
          r_ks_data  <= w_sym;
          r_ks_valid <= 1'b1;
          r_state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ks_ready) begin
            r_ks_valid <= 1'b0;
            r_state    <= ST_GEN1;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// tb_rc4_keystream_gen: four engine builds (default, DROP=3, KEY_MAX=4,
// W=4/KEY_MAX=2) checked against a plain software RC4 model and known vectors.
module tb_rc4_keystream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance stimulus (index 0..3)
  logic       rst       [4];
  logic [7:0] key_data  [4];
  logic       key_valid [4];
  logic       key_last  [4];
  logic       rekey     [4];
  logic       ks_ready  [4];

  // per-instance observations
  logic       kr [4];
  logic       kv [4];
  logic       bz [4];
  logic [7:0] kd [4];

  logic       kr_w0, kr_w1, kr_w2, kr_w3;
  logic       kv_w0, kv_w1, kv_w2, kv_w3;
  logic       bz_w0, bz_w1, bz_w2, bz_w3;
  logic [7:0] kd_w0, kd_w1, kd_w2;
  logic [3:0] kd_w3;

  int total = 0;
  int bad   = 0;

  int exp_key [10] = '{'hEB, 'h9F, 'h77, 'h81, 'hB7, 'h34, 'hCA, 'h72, 'hA7, 'h19};
  int exp_wiki [6] = '{'h60, 'h44, 'hDB, 'h6D, 'h41, 'hB7};

  always_comb begin
    kr[0] = kr_w0; kr[1] = kr_w1; kr[2] = kr_w2; kr[3] = kr_w3;
    kv[0] = kv_w0; kv[1] = kv_w1; kv[2] = kv_w2; kv[3] = kv_w3;
    bz[0] = bz_w0; bz[1] = bz_w1; bz[2] = bz_w2; bz[3] = bz_w3;
    kd[0] = kd_w0; kd[1] = kd_w1; kd[2] = kd_w2; kd[3] = {4'b0000, kd_w3};
  end

  rc4_keystream_gen #(.W(8), .KEY_MAX(16), .DROP(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .key_data(key_data[0]), .key_valid(key_valid[0]),
    .key_last(key_last[0]), .key_ready(kr_w0), .rekey(rekey[0]), .ks_data(kd_w0),
    .ks_valid(kv_w0), .ks_ready(ks_ready[0]), .busy(bz_w0)
  );

  rc4_keystream_gen #(.W(8), .KEY_MAX(16), .DROP(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .key_data(key_data[1]), .key_valid(key_valid[1]),
    .key_last(key_last[1]), .key_ready(kr_w1), .rekey(rekey[1]), .ks_data(kd_w1),
    .ks_valid(kv_w1), .ks_ready(ks_ready[1]), .busy(bz_w1)
  );

  rc4_keystream_gen #(.W(8), .KEY_MAX(4), .DROP(0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .key_data(key_data[2]), .key_valid(key_valid[2]),
    .key_last(key_last[2]), .key_ready(kr_w2), .rekey(rekey[2]), .ks_data(kd_w2),
    .ks_valid(kv_w2), .ks_ready(ks_ready[2]), .busy(bz_w2)
  );

  rc4_keystream_gen #(.W(4), .KEY_MAX(2), .DROP(0)) u_dut3 (
    .clk(clk), .rst(rst[3]), .key_data(key_data[3][3:0]), .key_valid(key_valid[3]),
    .key_last(key_last[3]), .key_ready(kr_w3), .rekey(rekey[3]), .ks_data(kd_w3),
    .ks_valid(kv_w3), .ks_ready(ks_ready[3]), .busy(bz_w3)
  );

  // Software RC4 (KSA + PRGA with drop) over a w-bit alphabet
  function automatic void rc4_ref(input int w, input int key[$], input int drop,
                                  input int n, output int ks[$]);
    int sz;
    int s[];
    int i;
    int j;
    int t;
    int tmp;
    sz = 1 << w;
    s = new[sz];
    for (int k = 0; k < sz; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < sz; k++) begin
      j = (j + s[k] + key[k % key.size()]) % sz;
      tmp = s[k]; s[k] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    ks.delete();
    for (int k = 0; k < drop + n; k++) begin
      i = (i + 1) % sz;
      j = (j + s[i]) % sz;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = (s[i] + s[j]) % sz;
      if (k >= drop) ks.push_back(s[t]);
    end
  endfunction

  function automatic void str_key(input string s, output int k[$]);
    k.delete();
    for (int i = 0; i < s.len(); i++) k.push_back(int'(s[i]));
  endfunction

  // Stream a key into instance d; all tasks start and end just after a negedge
  task automatic load_key(input int d, input int key[$], input bit gaps,
                          input bit use_last, input bit hold_rekey);
    int idx = 0;
    int budget = 300;
    bit xfer;
    rekey[d] = hold_rekey;
    while (idx < key.size() && budget > 0) begin
      budget--;
      if (gaps && $urandom_range(0, 2) == 0) begin
        key_valid[d] = 1'b0;
        key_last[d]  = 1'b0;
      end else begin
        key_valid[d] = 1'b1;
        key_data[d]  = 8'(key[idx]);
        key_last[d]  = use_last && (idx == key.size() - 1);
      end
      xfer = key_valid[d] && kr[d];
      @(negedge clk);
      if (xfer) idx++;
    end
    key_valid[d] = 1'b0;
    key_last[d]  = 1'b0;
    rekey[d]     = 1'b0;
    $display("load d=%0d len=%0d accepted=%0d", d, key.size(), idx);
    total++;
    if (idx != key.size()) begin
      bad++;
      $display("FAIL load_key d=%0d accepted=%0d required=%0d", d, idx, key.size());
    end
  endtask

  // Count edges until ks_valid is seen (bounded)
  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (kv[d] !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Collect n symbols, optionally with random back-pressure, checking that a
  // stalled symbol stays valid and unchanged
  task automatic collect(input int d, input int n, input bit stall, output int got[$]);
    int budget = 4000;
    bit holding = 1'b0;
    logic [7:0] held = 8'h00;
    bit rdy;
    got.delete();
    while (got.size() < n && budget > 0) begin
      budget--;
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (holding) begin
        total++;
        if (kv[d] !== 1'b1 || kd[d] !== held) begin
          bad++;
          $display("FAIL hold_stable d=%0d valid=%0b data=%02h required valid=1 data=%02h",
                   d, kv[d], kd[d], held);
        end
      end
      if (kv[d] === 1'b1) begin
        held    = kd[d];
        holding = !rdy;
        if (rdy) begin
          got.push_back(int'(kd[d]));
          $display("sym d=%0d idx=%0d data=%02h", d, got.size() - 1, kd[d]);
        end
      end else begin
        holding = 1'b0;
      end
      ks_ready[d] = rdy;
      @(negedge clk);
    end
  endtask

  // Pulse rekey for one edge and confirm the instance is back in LOAD
  task automatic pulse_rekey(input int d);
    rekey[d] = 1'b1;
    @(negedge clk);
    rekey[d] = 1'b0;
    total++;
    if (kr[d] !== 1'b1 || kv[d] !== 1'b0 || bz[d] !== 1'b0) begin
      bad++;
      $display("FAIL rekey_state d=%0d ready=%0b valid=%0b busy=%0b required 1/0/0",
               d, kr[d], kv[d], bz[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; key_valid[d] = 1'b0; key_last[d] = 1'b0;
      key_data[d] = 8'h00; rekey[d] = 1'b0; ks_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (kv[d] !== 1'b0 || kd[d] !== 8'h00 || kr[d] !== 1'b1 || bz[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset d=%0d valid=%0b data=%02h ready=%0b busy=%0b required 0/00/1/0",
                 d, kv[d], kd[d], kr[d], bz[d]);
      end
    end
  endtask

  task automatic test_key_basic();
    int key[$];
    int got[$];
    int ref_ks[$];
    int lat;
    str_key("Key", key);
    ks_ready[0] = 1'b1;
    load_key(0, key, 1'b0, 1'b1, 1'b0);
    wait_valid(0, lat);
    total++;
    if (lat != 770) begin
      bad++;
      $display("FAIL key_latency got=%0d required=770", lat);
    end
    collect(0, 10, 1'b0, got);
    rc4_ref(8, key, 0, 10, ref_ks);
    total++;
    if (got.size() != 10) begin
      bad++;
      $display("FAIL key_count got=%0d required=10", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != exp_key[k]) begin
        bad++;
        $display("FAIL key_vector idx=%0d got=%02h required=%02h", k, got[k], exp_key[k]);
      end
      total++;
      if (got[k] != ref_ks[k]) begin
        bad++;
        $display("FAIL key_model idx=%0d got=%02h required=%02h", k, got[k], ref_ks[k]);
      end
    end
  endtask

  task automatic test_stall_wiki();
    int key[$];
    int got[$];
    int ref_ks[$];
    int lat;
    pulse_rekey(0);
    str_key("Wiki", key);
    ks_ready[0] = 1'b0;
    // rekey held high while loading must be ignored in LOAD
    load_key(0, key, 1'b0, 1'b1, 1'b1);
    wait_valid(0, lat);
    total++;
    if (lat != 770) begin
      bad++;
      $display("FAIL wiki_latency got=%0d required=770", lat);
    end
    collect(0, 30, 1'b1, got);
    rc4_ref(8, key, 0, 30, ref_ks);
    total++;
    if (got.size() != 30) begin
      bad++;
      $display("FAIL wiki_count got=%0d required=30", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      if (k < 6) begin
        total++;
        if (got[k] != exp_wiki[k]) begin
          bad++;
          $display("FAIL wiki_vector idx=%0d got=%02h required=%02h", k, got[k], exp_wiki[k]);
        end
      end
      total++;
      if (got[k] != ref_ks[k]) begin
        bad++;
        $display("FAIL wiki_model idx=%0d got=%02h required=%02h", k, got[k], ref_ks[k]);
      end
    end
  endtask

  task automatic test_rekey_ksa();
    int key[$];
    int got[$];
    int lat;
    int m;
    pulse_rekey(0);
    ks_ready[0] = 1'b1;
    str_key("Secret", key);
    load_key(0, key, 1'b1, 1'b1, 1'b0);
    // 256 INIT edges, then KSA1/KSA2 alternate: odd edge counts land in KSA2
    m = $urandom_range(0, 250);
    repeat (257 + 2 * m) @(negedge clk);
    total++;
    if (bz[0] !== 1'b1 || kr[0] !== 1'b0) begin
      bad++;
      $display("FAIL ksa_busy busy=%0b ready=%0b required 1/0", bz[0], kr[0]);
    end
    pulse_rekey(0);
    str_key("Key", key);
    load_key(0, key, 1'b0, 1'b1, 1'b0);
    wait_valid(0, lat);
    total++;
    if (lat != 770) begin
      bad++;
      $display("FAIL rekey_latency got=%0d required=770", lat);
    end
    collect(0, 5, 1'b0, got);
    total++;
    if (got.size() != 5) begin
      bad++;
      $display("FAIL rekey_count got=%0d required=5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != exp_key[k]) begin
        bad++;
        $display("FAIL rekey_vector idx=%0d got=%02h required=%02h", k, got[k], exp_key[k]);
      end
    end
  endtask

  task automatic test_rekey_hold();
    int cnt = 0;
    logic [7:0] held;
    ks_ready[0] = 1'b0;
    while (kv[0] !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (kv[0] !== 1'b1) begin
      bad++;
      $display("FAIL hold_reach valid=%0b required=1", kv[0]);
    end
    held = kd[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (kv[0] !== 1'b1 || kd[0] !== held) begin
        bad++;
        $display("FAIL hold_static valid=%0b data=%02h required valid=1 data=%02h",
                 kv[0], kd[0], held);
      end
    end
    pulse_rekey(0);
  endtask

  task automatic test_random_keys();
    int key[$];
    int got[$];
    int ref_ks[$];
    int len;
    bit use_last;
    for (int r = 0; r < 2; r++) begin
      pulse_rekey(0);
      len = $urandom_range(1, 16);
      use_last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      key.delete();
      for (int k = 0; k < len; k++) key.push_back($urandom_range(0, 255));
      ks_ready[0] = 1'b1;
      load_key(0, key, 1'b1, use_last, 1'b0);
      collect(0, 12, 1'b1, got);
      rc4_ref(8, key, 0, 12, ref_ks);
      total++;
      if (got.size() != 12) begin
        bad++;
        $display("FAIL rand_count run=%0d got=%0d required=12", r, got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
        total++;
        if (got[k] != ref_ks[k]) begin
          bad++;
          $display("FAIL rand_model run=%0d len=%0d idx=%0d got=%02h required=%02h",
                   r, len, k, got[k], ref_ks[k]);
        end
      end
    end
  endtask

  task automatic test_drop();
    int key[$];
    int got[$];
    int ref_ks[$];
    int lat;
    str_key("Key", key);
    ks_ready[1] = 1'b1;
    load_key(1, key, 1'b0, 1'b1, 1'b0);
    wait_valid(1, lat);
    total++;
    if (lat != 776) begin
      bad++;
      $display("FAIL drop_latency got=%0d required=776", lat);
    end
    collect(1, 6, 1'b0, got);
    rc4_ref(8, key, 3, 6, ref_ks);
    total++;
    if (got.size() != 6) begin
      bad++;
      $display("FAIL drop_count got=%0d required=6", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != exp_key[k + 3]) begin
        bad++;
        $display("FAIL drop_vector idx=%0d got=%02h required=%02h", k, got[k], exp_key[k + 3]);
      end
      total++;
      if (got[k] != ref_ks[k]) begin
        bad++;
        $display("FAIL drop_model idx=%0d got=%02h required=%02h", k, got[k], ref_ks[k]);
      end
    end
  endtask

  task automatic test_key_max();
    int key[$];
    int used[$];
    int got[$];
    int ref_ks[$];
    int acc = 0;
    int lat;
    for (int k = 0; k < 5; k++) key.push_back($urandom_range(0, 255));
    ks_ready[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      key_valid[2] = 1'b1;
      key_data[2]  = 8'(key[k]);
      key_last[2]  = 1'b0;
      if (k == 4) begin
        total++;
        if (kr[2] !== 1'b0) begin
          bad++;
          $display("FAIL keymax_ready ready=%0b required=0", kr[2]);
        end
      end
      if (kr[2] === 1'b1) acc++;
      @(negedge clk);
    end
    key_valid[2] = 1'b0;
    $display("load d=2 offered=5 accepted=%0d", acc);
    total++;
    if (acc != 4) begin
      bad++;
      $display("FAIL keymax_accepted got=%0d required=4", acc);
    end
    // one INIT edge already elapsed during the fifth offer
    wait_valid(2, lat);
    total++;
    if (lat + 1 != 770) begin
      bad++;
      $display("FAIL keymax_latency got=%0d required=770", lat + 1);
    end
    for (int k = 0; k < 4; k++) used.push_back(key[k]);
    collect(2, 8, 1'b1, got);
    rc4_ref(8, used, 0, 8, ref_ks);
    total++;
    if (got.size() != 8) begin
      bad++;
      $display("FAIL keymax_count got=%0d required=8", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if (got[k] != ref_ks[k]) begin
        bad++;
        $display("FAIL keymax_model idx=%0d got=%02h required=%02h", k, got[k], ref_ks[k]);
      end
    end
  endtask

  task automatic test_small_width();
    int key[$];
    int got[$];
    int ref_ks[$];
    int lat;
    int cnt;
    int len;
    for (int r = 0; r < 2; r++) begin
      len = $urandom_range(1, 2);
      key.delete();
      for (int k = 0; k < len; k++) key.push_back($urandom_range(0, 15));
      ks_ready[3] = 1'b1;
      load_key(3, key, 1'b0, (len < 2) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
      wait_valid(3, lat);
      total++;
      if (lat != 50) begin
        bad++;
        $display("FAIL w4_latency run=%0d got=%0d required=50", r, lat);
      end
      collect(3, 10, 1'b1, got);
      rc4_ref(4, key, 0, 10, ref_ks);
      total++;
      if (got.size() != 10) begin
        bad++;
        $display("FAIL w4_count run=%0d got=%0d required=10", r, got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
        total++;
        if (got[k] != ref_ks[k]) begin
          bad++;
          $display("FAIL w4_model run=%0d idx=%0d got=%01h required=%01h", r, k, got[k], ref_ks[k]);
        end
      end
      // park in HOLD with a valid symbol, then reset mid-generation
      ks_ready[3] = 1'b0;
      cnt = 0;
      while (kv[3] !== 1'b1 && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      rst[3] = 1'b1;
      @(negedge clk);
      rst[3] = 1'b0;
      total++;
      if (kv[3] !== 1'b0 || kr[3] !== 1'b1 || bz[3] !== 1'b0 || kd[3] !== 8'h00) begin
        bad++;
        $display("FAIL w4_reset valid=%0b ready=%0b busy=%0b data=%02h required 0/1/0/00",
                 kv[3], kr[3], bz[3], kd[3]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_basic();
    test_stall_wiki();
    test_rekey_ksa();
    test_rekey_hold();
    test_random_keys();
    test_drop();
    test_key_max();
    test_small_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
